chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
Multi-cycle, parametrised successor to the gate-level full adder. Adds two WIDTH-bit operands plus a carry-in. Each clock processes CHUNK bits, least-significant chunk first, with the carry held in a register between chunks. Uses a START/BUSY/DONE handshake, so a narrow adder slice can serve wide datapaths in the DSD arithmetic library.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per clock; 1 gives a pure bit-serial adder
NCHUNK (localparam), WIDTH/CHUNK, cycles per operation

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  asynchronous, active-high reset
START  input  1  request; sampled only in IDLE or DONE
X  input  WIDTH  operand A; captured on the START-accept edge
Y  input  WIDTH  operand B; captured on the START-accept edge
C_I  input  1  carry-in; captured on the START-accept edge
SUM  output  WIDTH  registered result; held until the next completion
C_O  output  1  registered carry-out of the MSB
OVF  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)
BUSY  output  1  high while chunks are being processed
DONE  output  1  one-cycle pulse; SUM/C_O/OVF are valid from this cycle on

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; SUM=0, C_O=0, OVF=0, BUSY=0, DONE=0; operand registers, carry register and chunk counter cleared.
- States: IDLE, BUSY, DONE. BUSY and DONE are decoded directly from state.
- IDLE, START=1 at an edge:
  - capture X, Y; carry_reg=C_I; cnt=0; go to BUSY.
- IDLE, START=0: stay in IDLE.
- BUSY, each edge:
  - {c, s} = X_reg[cnt*CHUNK +: CHUNK] + Y_reg[same] + carry_reg (CHUNK+1-bit result).
  - Write s into result_reg[same slice]; carry_reg=c; cnt=cnt+1.
  - On the chunk with cnt=NCHUNK-1:
    - load SUM with the full result, including the slice written this edge;
    - C_O=c; OVF = carry into bit WIDTH-1 XOR c;
    - go to DONE.
- Latency: START captured at edge 0; chunks processed at edges 1..NCHUNK. DONE=1 for exactly the one cycle after edge NCHUNK, and the new SUM/C_O/OVF are visible in that cycle. Back-to-back throughput is one result per NCHUNK+1 cycles.
- DONE, START=1: accept a new operation (capture, go to BUSY). SUM/C_O/OVF keep the old result until the new one completes.
- DONE, START=0: go to IDLE; outputs held.
- START during BUSY: ignored. No queueing, no error.
- X/Y/C_I changes after capture have no effect on the operation in flight.
- RST asserted mid-operation: immediate abort to the reset values above; no DONE pulse is produced.
- Arithmetic is unsigned modulo 2^WIDTH. C_O is the unsigned carry; OVF is two's-complement overflow.
- NCHUNK=1: single BUSY cycle, so DONE follows START by 2 edges.
- Counter width: $clog2(NCHUNK), minimum 1 bit.

Optional Feature:
- Macro: CHUNK_SERIAL_ADDER_SUB_EN.
- Defined:
  - extra input SUB (1 bit), captured with the operands.
  - SUB=1: Y_reg loaded with ~Y and carry_reg forced to 1 (C_I ignored), so the block computes X-Y.
  - C_O=1 means no borrow; OVF is signed subtract overflow.
- Undefined:
  - SUB port absent; addition only.

Test Plan:
- WIDTH=16, CHUNK=4: assert RST mid-BUSY with X=0x1234, Y=0x1111 -> all outputs 0 immediately, state IDLE, no DONE pulse after RST releases.
- X=0x00FF, Y=0x0001, C_I=0, START 1 cycle -> BUSY for 4 cycles, DONE in the 5th cycle after the capture edge, SUM=0x0100, C_O=0, OVF=0.
- Carry chain through every chunk: X=0xFFFF, Y=0x0000, C_I=1 -> SUM=0x0000, C_O=1, OVF=0.
- Signed overflow: X=0x7FFF, Y=0x0001, C_I=0 -> SUM=0x8000, C_O=0, OVF=1.
- Handshake:
  - START pulsed mid-BUSY -> ignored, exactly one DONE.
  - START held high in the DONE cycle with X=0x0002, Y=0x0003 -> second op accepted, previous SUM held until the next DONE, then SUM=0x0005.
- Exhaustive at WIDTH=3, CHUNK=1 over all 128 X/Y/C_I combinations -> SUM/C_O/OVF match the behavioural sum. With CHUNK_SERIAL_ADDER_SUB_EN: 0x0005-0x0007 -> SUM=0xFFFE, C_O=0.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - chunk-serial WIDTH-bit adder with START/BUSY/DONE handshake
// Optional feature macro: CHUNK_SERIAL_ADDER_SUB_EN adds a SUB input (X-Y mode).
`timescale 1ns/1ps
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_I,
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic [WIDTH-1:0] SUM,
  output logic             C_O,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] y_load;
  logic             carry_load;
  logic [CHUNK:0]   slice_sum;
  logic             last_chunk;
  int               base;

  // Operand conditioning at capture: subtract is X + ~Y + 1
  always_comb begin
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    y_load     = SUB ? ~Y : Y;
    carry_load = SUB ? 1'b1 : C_I;
`else
    y_load     = Y;
    carry_load = C_I;
`endif
  end

  // One CHUNK-wide add of the slice selected by the chunk counter
  always_comb begin
    base      = int'(cnt_q) * CHUNK;
    slice_sum = {1'b0, x_q[base +: CHUNK]} + {1'b0, y_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  // Next-state logic for the handshake FSM and datapath registers
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_BUSY: begin
        res_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d              = slice_sum[CHUNK];
        if (last_chunk) begin
          sum_d   = res_d;
          co_d    = slice_sum[CHUNK];
          // carry into the MSB is recovered from the MSB's own sum bit
          ovf_d   = x_q[WIDTH-1] ^ y_q[WIDTH-1] ^ res_d[WIDTH-1] ^ slice_sum[CHUNK];
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        if (START) begin
          x_d     = X;
          y_d     = y_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign SUM  = sum_q;
  assign C_O  = co_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q == S_BUSY);
  assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - self-checking bench for chunk_serial_adder (16/4 and 3/1 builds)
`timescale 1ns/1ps
module tb_chunk_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, c_i16;
  logic [15:0] x16, y16;
  logic [15:0] sum16;
  logic        co16, ovf16, busy16, done16;
  logic        start3, c_i3;
  logic [2:0]  x3, y3;
  logic [2:0]  sum3;
  logic        co3, ovf3, busy3, done3;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  logic        sub16, sub3;
`endif

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .CLK(clk), .RST(rst), .START(start16), .X(x16), .Y(y16), .C_I(c_i16),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .SUB(sub16),
`endif
    .SUM(sum16), .C_O(co16), .OVF(ovf16), .BUSY(busy16), .DONE(done16)
  );

  chunk_serial_adder #(.WIDTH(3), .CHUNK(1)) u3 (
    .CLK(clk), .RST(rst), .START(start3), .X(x3), .Y(y3), .C_I(c_i3),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .SUB(sub3),
`endif
    .SUM(sum3), .C_O(co3), .OVF(ovf3), .BUSY(busy3), .DONE(done3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for SUM/C_O, signed range test for OVF
  function automatic void model(input int w, input int a, input int b, input int ci, input int is_sub,
                                output int s, output int co, output int ov);
    int m  = 1 << w;
    int h  = 1 << (w - 1);
    int sa = (a >= h) ? a - m : a;
    int sb = (b >= h) ? b - m : b;
    int u, sv;
    if (is_sub != 0) begin
      u  = a - b;
      co = (a >= b) ? 1 : 0;
      sv = sa - sb;
    end else begin
      u  = a + b + ci;
      co = (u >= m) ? 1 : 0;
      sv = sa + sb + ci;
    end
    s  = ((u % m) + m) % m;
    ov = (sv >= h || sv < -h) ? 1 : 0;
  endfunction

  task automatic do16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic is_sub,
                      output logic [15:0] s, output logic co, output logic ov,
                      output int lat, output logic bsy);
    @(negedge clk);
    x16 = a; y16 = b; c_i16 = ci; start16 = 1'b1;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    sub16 = is_sub;
`endif
    @(negedge clk);
    start16 = 1'b0;
    bsy = busy16;
    x16 = 16'($urandom); y16 = 16'($urandom); c_i16 = 1'($urandom);
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    sub16 = ~is_sub;
`endif
    lat = 0;
    while (!done16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum16; co = co16; ov = ovf16;
  endtask

  task automatic do3(input logic [2:0] a, input logic [2:0] b, input logic ci, input logic is_sub,
                     output logic [2:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    x3 = a; y3 = b; c_i3 = ci; start3 = 1'b1;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    sub3 = is_sub;
`endif
    @(negedge clk);
    start3 = 1'b0;
    x3 = 3'($urandom); y3 = 3'($urandom);
    lat = 0;
    while (!done3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum3; co = co3; ov = ovf3;
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [15:0] s;
    logic [2:0]  s3;
    logic        co, ov, bsy, is_sub;
    int          lat, ndone, es, eco, eov;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[5] = '{16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0};

    rst = 1'b1; start16 = 1'b0; start3 = 1'b0;
    x16 = '0; y16 = '0; c_i16 = 1'b0; x3 = '0; y3 = '0; c_i3 = 1'b0;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    sub16 = 1'b0; sub3 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_sum",  32'(sum16), 32'h0);
    check("reset_co",   32'(co16),  32'h0);
    check("reset_ovf",  32'(ovf16), 32'h0);
    check("reset_busy", 32'(busy16), 32'h0);
    check("reset_done", 32'(done16), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do16(vecs[i].x, vecs[i].y, vecs[i].ci, 1'b0, s, co, ov, lat, bsy);
      check($sformatf("vec%0d_busy", i), 32'(bsy), 32'h1);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      check($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].co));
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
    end

    // Reset mid-operation: immediate clear, no DONE afterwards
    @(negedge clk);
    x16 = 16'h1234; y16 = 16'h1111; c_i16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_sum",  32'(sum16), 32'h0);
    check("abort_co",   32'(co16),  32'h0);
    check("abort_ovf",  32'(ovf16), 32'h0);
    check("abort_busy", 32'(busy16), 32'h0);
    check("abort_done", 32'(done16), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_idle_busy", 32'(busy16), 32'h0);

    // START pulsed while busy is ignored
    @(negedge clk);
    x16 = 16'h0100; y16 = 16'h0200; c_i16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    ndone = 0;
    @(negedge clk);
    x16 = 16'h7777; y16 = 16'h7777; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (12) begin
      if (done16) ndone++;
      @(negedge clk);
    end
    check("midbusy_done_count", 32'(ndone), 32'd1);
    check("midbusy_sum", 32'(sum16), 32'h0300);

    // Back-to-back: START held in the DONE cycle
    do16(16'h1234, 16'h1111, 1'b0, 1'b0, s, co, ov, lat, bsy);
    check("b2b_first_sum", 32'(s), 32'h2345);
    x16 = 16'h0002; y16 = 16'h0003; c_i16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    check("b2b_busy", 32'(busy16), 32'h1);
    check("b2b_held_sum", 32'(sum16), 32'h2345);
    lat = 0;
    while (!done16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'd4);
    check("b2b_sum", 32'(sum16), 32'h0005);

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    do16(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, ov, lat, bsy);
    check("sub_sum", 32'(s), 32'hFFFE);
    check("sub_co", 32'(co), 32'h0);
    check("sub_ovf", 32'(ov), 32'h0);
`endif

    // Randomized operations against the integer model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      logic ci;
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      if (i % 8 == 0) a = 16'hFFFF;
      is_sub = 1'b0;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
      is_sub = 1'($urandom);
`endif
      do16(a, b, ci, is_sub, s, co, ov, lat, bsy);
      model(16, int'(a), int'(b), int'(ci), int'(is_sub), es, eco, eov);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("rnd%0d_sum a=%h b=%h ci=%0d sub=%0d", i, a, b, ci, is_sub), 32'(s), 32'(es));
      check($sformatf("rnd%0d_co", i), 32'(co), 32'(eco));
      check($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
    end

    // Exhaustive 3-bit bit-serial build
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          do3(3'(a), 3'(b), 1'(ci), 1'b0, s3, co, ov, lat);
          model(3, a, b, ci, 0, es, eco, eov);
          check($sformatf("w3_latency a=%0d b=%0d ci=%0d", a, b, ci), 32'(lat), 32'd3);
          check($sformatf("w3_sum a=%0d b=%0d ci=%0d", a, b, ci), 32'(s3), 32'(es));
          check($sformatf("w3_co a=%0d b=%0d ci=%0d", a, b, ci), 32'(co), 32'(eco));
          check($sformatf("w3_ovf a=%0d b=%0d ci=%0d", a, b, ci), 32'(ov), 32'(eov));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
